axi4_mid_read_burst_engine: RTL and testbench

Parametrised AXI4 read master for the MID memory port. It takes a linear read command (address, beat count, endianness mode), splits it into INCR bursts that respect AXI4 length and 4 KB rules, and reserves buffer credit so `rready` can stay high. It returns the data as a ready/valid stream with optional per-beat byte swapping and a command-level `last` flag. It sits between engine-side request logic and the MID AXI4 master read channel.

---
 rtl/axi4_mid_read_burst_engine.sv | 190 +++++++++++++++++++
 tb/tb_axi4_mid_read_burst_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mid_read_burst_engine.sv
// AXI4 read master for the MID memory port. Splits a linear read command into 4 KB-safe
// INCR bursts, reserves return-buffer credit before each AR, and streams the beats out.
module axi4_mid_read_burst_engine #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 32,
  parameter int ID_W          = 1,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_beats,
  input  logic              cmd_swap,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic [3:0]        m_axi_arregion,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic [ID_W-1:0]   m_axi_rid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = $clog2(BYTES);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, AR, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       remaining_q, beats_q, pop_count_q;
  logic              swap_q;
  logic [8:0]        len_q;
  logic [CNT_W-1:0]  outstanding_q, fifo_count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic              live_q, done_q, error_q;

  logic              cmd_hs, ar_hs, r_hs, pop, last_pop, calc_go;
  logic [12:0]       page_bytes;
  logic [31:0]       page_beats, len_calc, credit;
  logic [CNT_W-1:0]  out_inc, out_dec, cnt_inc, cnt_dec;
  logic              unused_ok;

  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = d[8*(BYTES-1-i) +: 8];
    return r;
  endfunction

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign pop      = out_valid && out_ready;
  assign last_pop = pop && (pop_count_q == beats_q - 32'd1);

  // Burst length is the tightest of: beats left, the burst cap, and beats to the 4 KB page end.
  assign page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign page_beats = {19'd0, page_bytes} >> SIZE_LOG;
  assign credit     = 32'(FIFO_DEPTH) - (32'(fifo_count_q) + 32'(outstanding_q));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    len_calc = remaining_q;
    if (len_calc > 32'(MAX_BURST_LEN)) len_calc = 32'(MAX_BURST_LEN);
    if (len_calc > page_beats)         len_calc = page_beats;
  end

  assign calc_go = (state_q == CALC) && (credit >= len_calc);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs && cmd_beats != 32'd0) state_d = CALC;
      CALC:    if (calc_go) state_d = AR;
      AR:      if (ar_hs) state_d = (remaining_q == 32'(len_q)) ? DRAIN : CALC;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  assign out_inc = calc_go ? CNT_W'(len_calc) : '0;
  assign out_dec = r_hs ? CNT_W'(1) : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      live_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      swap_q        <= 1'b0;
      len_q         <= '0;
      pop_count_q   <= '0;
      outstanding_q <= '0;
    end else begin
      live_q <= 1'b1;
      done_q <= (cmd_hs && cmd_beats == 32'd0) || (state_q == DRAIN && last_pop);
      if (cmd_hs) begin
        addr_q      <= cmd_addr;
        remaining_q <= cmd_beats;
        beats_q     <= cmd_beats;
        swap_q      <= cmd_swap;
      end else if (ar_hs) begin
        addr_q      <= addr_q + (ADDR_W'(len_q) << SIZE_LOG);
        remaining_q <= remaining_q - 32'(len_q);
      end
      if (calc_go) len_q <= len_calc[8:0];
      if (cmd_hs)                              error_q <= 1'b0;
      else if (r_hs && m_axi_rresp != 2'b00)   error_q <= 1'b1;
      if (cmd_hs)   pop_count_q <= '0;
      else if (pop) pop_count_q <= pop_count_q + 32'd1;
      // Credit is reserved on leaving CALC and returned one beat at a time as R data lands.
      outstanding_q <= outstanding_q + out_inc - out_dec;
    end
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: buffer storage has no reset; out_valid is derived from the count, which is reset.
    if (r_hs) fifo_mem[wr_ptr_q] <= swap_q ? byte_swap(m_axi_rdata) : m_axi_rdata;
  end

  assign cnt_inc = r_hs ? CNT_W'(1) : '0;
  assign cnt_dec = pop ? CNT_W'(1) : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (r_hs) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_count_q <= fifo_count_q + cnt_inc - cnt_dec;
    end
  end

  assign cmd_ready      = live_q && (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign m_axi_rready   = live_q;

  assign m_axi_arvalid  = (state_q == AR);
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'(len_q - 9'd1);
  assign m_axi_arsize   = 3'(SIZE_LOG);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arid     = '0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;

  assign out_valid = (fifo_count_q != '0);
  assign out_data  = fifo_mem[rd_ptr_q];
  assign out_last  = out_valid && (pop_count_q == beats_q - 32'd1);

  // rlast/rid carry no control meaning here; beats are counted against reserved credit.
  assign unused_ok = &{1'b0, m_axi_rlast, m_axi_rid};
endmodule

// File: tb/tb_axi4_mid_read_burst_engine.sv
// Directed bench for axi4_mid_read_burst_engine: a small AXI4 read slave returns
// address-derived words and every comparison is an immediate assertion.
`timescale 1ns/1ps
module tb_axi4_mid_read_burst_engine;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int ID_W   = 1;

  logic              ap_clk, ap_rst_n;
  logic              cmd_valid, cmd_ready, cmd_swap;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_beats;
  logic              m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize, m_axi_arprot;
  logic [1:0]        m_axi_arburst, m_axi_rresp;
  logic [ID_W-1:0]   m_axi_arid, m_axi_rid;
  logic [3:0]        m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic              m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DATA_W-1:0] m_axi_rdata, out_data;
  logic              out_valid, out_ready, out_last, busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } burst_t;

  burst_t      rd_q[$];
  logic [63:0] log_addr[$];
  int          log_len[$];
  int          ar_delay = 0;
  int          ar_allow = -1;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_word = 32'h0;
  int          err_beat = -1;
  int          r_total = 0;

  axi4_mid_read_burst_engine dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_beats(cmd_beats), .cmd_swap(cmd_swap),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .error(error)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [63:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [63:0] log_a(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic int log_l(input int i);
    return (i < log_len.size()) ? log_len[i] : -1;
  endfunction

  // Simple AXI4 read slave: optional AR wait states, one R beat per cycle, in order.
  initial begin : slave
    int   idx;
    bit   r_drv, r_rdy, ar_prev;
    int   ar_wait;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;
    idx = 0; r_drv = 0; r_rdy = 0; ar_prev = 0; ar_wait = 0;
    prev_addr = '0; prev_len = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        rd_q.delete();
        idx = 0; r_drv = 0; ar_wait = 0; ar_prev = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else begin
        if (r_drv && r_rdy) begin
          r_total++;
          idx++;
          if (idx == rd_q[0].len) begin
            void'(rd_q.pop_front());
            idx = 0;
          end
        end
        if (rd_q.size() != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = use_fixed ? fixed_word : pattern(rd_q[0].addr + 64'(4 * idx));
          m_axi_rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (idx == rd_q[0].len - 1);
          r_drv = 1; r_rdy = m_axi_rready;
        end else begin
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; r_drv = 0;
        end
        if (m_axi_arvalid) begin
          if (ar_prev) begin
            check("ar_stable_addr", m_axi_araddr, prev_addr);
            check("ar_stable_len", 64'(m_axi_arlen), 64'(prev_len));
          end
          if (ar_wait >= ar_delay && ar_allow != 0) begin
            m_axi_arready = 1'b1;
            rd_q.push_back('{addr: m_axi_araddr, len: int'(m_axi_arlen) + 1});
            log_addr.push_back(m_axi_araddr);
            log_len.push_back(int'(m_axi_arlen));
            if (ar_allow > 0) ar_allow--;
            ar_wait = 0; ar_prev = 0;
          end else begin
            m_axi_arready = 1'b0;
            ar_wait++; ar_prev = 1;
            prev_addr = m_axi_araddr; prev_len = m_axi_arlen;
          end
        end else begin
          m_axi_arready = 1'b0; ar_wait = 0; ar_prev = 0;
        end
      end
    end
  end

  task automatic issue_cmd(input logic [63:0] a, input logic [31:0] n, input logic sw);
    int waited = 0;
    @(negedge ap_clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n; cmd_swap = sw;
    while (!cmd_ready && waited < 50) begin
      @(negedge ap_clk);
      waited++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
  endtask

  // Drains n beats with out_ready high, checking data order, out_last and the done pulse.
  task automatic collect(input logic [63:0] a0, input int n, input logic sw, input logic fx);
    int got = 0;
    int cyc = 0;
    logic [31:0] raw;
    out_ready = 1'b1;
    while (got < n && cyc < 600) begin
      if (out_valid) begin
        raw = fx ? fixed_word : pattern(a0 + 64'(4 * got));
        check("out_data", 64'(out_data), 64'(sw ? swap32(raw) : raw));
        check("out_last", 64'(out_last), 64'(got == n - 1));
        got++;
      end
      @(negedge ap_clk);
      cyc++;
    end
    check("beats_out", 64'(got), 64'(n));
    check("done_pulse", 64'(done), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    @(negedge ap_clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int r0;
    ap_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_swap = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    #2 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_rready", 64'(m_axi_rready), 64'd1);

    // 4 beats at 0x1000, swapped fixed word, one AR wait state
    ar_delay = 1; use_fixed = 1'b1; fixed_word = 32'h1122_3344;
    issue_cmd(64'h1000, 32'd4, 1'b1);
    check("calc_no_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("calc_busy", 64'(busy), 64'd1);
    @(negedge ap_clk);
    check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("t1_araddr", m_axi_araddr, 64'h1000);
    check("t1_arlen", 64'(m_axi_arlen), 64'd3);
    check("t1_arsize", 64'(m_axi_arsize), 64'd2);
    check("t1_arburst", 64'(m_axi_arburst), 64'd1);
    check("t1_arcache", 64'(m_axi_arcache), 64'd3);
    collect(64'h1000, 4, 1'b1, 1'b1);
    check("t1_error", 64'(error), 64'd0);
    use_fixed = 1'b0; ar_delay = 0;
    log_addr.delete(); log_len.delete();

    // 4 KB crossing
    issue_cmd(64'hFF8, 32'd8, 1'b0);
    collect(64'hFF8, 8, 1'b0, 1'b0);
    check("t2_ar_count", 64'(log_addr.size()), 64'd2);
    check("t2_ar0_addr", log_a(0), 64'hFF8);
    check("t2_ar0_len", 64'(log_l(0)), 64'd1);
    check("t2_ar1_addr", log_a(1), 64'h1000);
    check("t2_ar1_len", 64'(log_l(1)), 64'd5);
    log_addr.delete(); log_len.delete();

    // Length split 40 beats
    issue_cmd(64'h0, 32'd40, 1'b0);
    collect(64'h0, 40, 1'b0, 1'b0);
    check("t3_ar_count", 64'(log_addr.size()), 64'd3);
    check("t3_ar0_addr", log_a(0), 64'h0);
    check("t3_ar0_len", 64'(log_l(0)), 64'd15);
    check("t3_ar1_addr", log_a(1), 64'h40);
    check("t3_ar1_len", 64'(log_l(1)), 64'd15);
    check("t3_ar2_addr", log_a(2), 64'h80);
    check("t3_ar2_len", 64'(log_l(2)), 64'd7);
    log_addr.delete(); log_len.delete();

    // Backpressure: credit stops AR issue at FIFO_DEPTH beats
    out_ready = 1'b0;
    r0 = r_total;
    issue_cmd(64'h2000, 32'd64, 1'b1);
    repeat (150) @(negedge ap_clk);
    check("t4_beats_accepted", 64'(r_total - r0), 64'd32);
    check("t4_ar_count_stalled", 64'(log_addr.size()), 64'd2);
    check("t4_arvalid_stalled", 64'(m_axi_arvalid), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    collect(64'h2000, 64, 1'b1, 1'b0);
    check("t4_ar_count", 64'(log_addr.size()), 64'd4);
    check("t4_ar3_addr", log_a(3), 64'h20C0);
    check("t4_ar3_len", 64'(log_l(3)), 64'd15);
    log_addr.delete(); log_len.delete();

    // SLVERR on beat 2 of 4
    err_beat = r_total + 1;
    issue_cmd(64'h3000, 32'd4, 1'b0);
    collect(64'h3000, 4, 1'b0, 1'b0);
    check("t5_error_set", 64'(error), 64'd1);
    repeat (3) @(negedge ap_clk);
    check("t5_error_sticky", 64'(error), 64'd1);
    err_beat = -1;
    log_addr.delete(); log_len.delete();

    // Zero-beat command: single done pulse, no AR, clears error
    issue_cmd(64'h6000, 32'd0, 1'b0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_error_cleared", 64'(error), 64'd0);
    @(negedge ap_clk);
    check("t6_done_once", 64'(done), 64'd0);
    repeat (5) @(negedge ap_clk);
    check("t6_no_ar", 64'(log_addr.size()), 64'd0);
    check("t6_no_more_done", 64'(done), 64'd0);

    // Reset mid-burst with a stalled AR and a non-empty FIFO
    ar_allow = 1; out_ready = 1'b0;
    issue_cmd(64'h4000, 32'd64, 1'b0);
    repeat (40) @(negedge ap_clk);
    check("t7_pre_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("t7_pre_out_valid", 64'(out_valid), 64'd1);
    check("t7_pre_busy", 64'(busy), 64'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("t7_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("t7_rst_out_valid", 64'(out_valid), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    ar_allow = -1;
    log_addr.delete(); log_len.delete();
    issue_cmd(64'h5000, 32'd4, 1'b0);
    collect(64'h5000, 4, 1'b0, 1'b0);
    check("t7_ar_count", 64'(log_addr.size()), 64'd1);
    check("t7_ar0_addr", log_a(0), 64'h5000);
    check("t7_ar0_len", 64'(log_l(0)), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
